// File: rtl/n64_vmode_detect.sv
// n64_vmode_detect
//   Measures lines per video field from the sampled sync stream, derives
//   PAL/NTSC and 240p/480i candidates on every VSYNC falling edge, and
//   commits a mode only after it has been seen on several consecutive
//   fields. Declares sync lost when no VSYNC arrives within a line budget.
//
// Ports:
//   VCLK              video clock
//   RST               synchronous reset, active-high
//   nVDSYNC           active-low sample enable; state advances only when 0
//   Sync_pre/Sync_cur previous/current sync sample ([3]=nVSYNC, [1]=nHSYNC)
//   vinfo_o           committed {palmode, n64_480i}
//   field_id_o        current field parity (1 = odd)
//   lines_per_field_o line count of the last completed field
//   vmode_valid_o     a committed mode is valid
//   mode_changed_o    one-cycle pulse when vinfo_o takes a new value
module n64_vmode_detect #(
  parameter int unsigned LINECNT_W       = 10,
  parameter int unsigned PAL_LINE_THRESH = 288,
  parameter int unsigned STABLE_FIELDS   = 4,
  parameter int unsigned TIMEOUT_LINES   = 640
) (
  input  logic                 VCLK,
  input  logic                 RST,
  input  logic                 nVDSYNC,
  input  logic [3:0]           Sync_pre,
  input  logic [3:0]           Sync_cur,
  output logic [1:0]           vinfo_o,
  output logic                 field_id_o,
  output logic [LINECNT_W-1:0] lines_per_field_o,
  output logic                 vmode_valid_o,
  output logic                 mode_changed_o
);

  localparam logic [LINECNT_W-1:0] PAL_TH      = LINECNT_W'(PAL_LINE_THRESH);
  localparam logic [LINECNT_W-1:0] TIMEOUT_CNT = LINECNT_W'(TIMEOUT_LINES);
  localparam logic [3:0]           STAB_MAX    = 4'(STABLE_FIELDS - 1);
  localparam logic [4:0]           STAB_COMMIT = 5'(STABLE_FIELDS - 1);

  logic                 en, negv, negh;
  logic                 cand_p, cand_i, commit_ok;
  logic [1:0]           cand;
  logic [LINECNT_W-1:0] cnt_inc;
  logic                 unused_sync;

  logic [LINECNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [3:0]           stab_q, stab_d;
  logic [1:0]           pending_q, pending_d;
  logic                 seen_v_q, seen_v_d;
  logic [1:0]           vinfo_q, vinfo_d;
  logic                 field_id_q, field_id_d;
  logic [LINECNT_W-1:0] lpf_q, lpf_d;
  logic                 valid_q, valid_d;
  logic                 mode_changed_q, mode_changed_d;

  assign en          = ~nVDSYNC;
  assign negv        = Sync_pre[3] & ~Sync_cur[3];
  assign negh        = Sync_pre[1] & ~Sync_cur[1];
  assign unused_sync = ^{Sync_pre[2], Sync_pre[0], Sync_cur[2], Sync_cur[0]};

  // Candidates use the count and parity from before this edge updates them.
  assign cand_p    = (line_cnt_q >= PAL_TH);
  assign cand_i    = field_id_q ^ negh;
  assign cand      = {cand_p, cand_i};
  assign commit_ok = (STABLE_FIELDS == 1) ||
                     (({1'b0, stab_q} + 5'd1) >= STAB_COMMIT);
  assign cnt_inc   = (line_cnt_q == '1) ? line_cnt_q : line_cnt_q + 1'b1;

  always_comb begin
    line_cnt_d     = line_cnt_q;
    stab_d         = stab_q;
    pending_d      = pending_q;
    seen_v_d       = seen_v_q;
    vinfo_d        = vinfo_q;
    field_id_d     = field_id_q;
    lpf_d          = lpf_q;
    valid_d        = valid_q;
    mode_changed_d = 1'b0;

    if (en) begin
      if (negv) begin
        // A coincident HSYNC edge is not counted; it only marks parity.
        lpf_d      = line_cnt_q;
        line_cnt_d = '0;
        field_id_d = negh;
        if (!seen_v_q) begin
          // Parity history is meaningless until one VSYNC has been seen.
          seen_v_d = 1'b1;
        end else if (cand != pending_q) begin
          pending_d = cand;
          stab_d    = '0;
        end else begin
          if (stab_q < STAB_MAX) stab_d = stab_q + 4'd1;
          if (commit_ok) begin
            vinfo_d        = pending_q;
            valid_d        = 1'b1;
            mode_changed_d = (pending_q != vinfo_q);
          end
        end
      end else begin
        if (negh) line_cnt_d = cnt_inc;
        // Lost sync: drop validity and restart the VSYNC history while
        // keeping the last reported mode and measurements visible.
        if (line_cnt_d >= TIMEOUT_CNT) begin
          valid_d  = 1'b0;
          seen_v_d = 1'b0;
          stab_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge VCLK) begin
    if (RST) begin
      line_cnt_q     <= '0;
      stab_q         <= '0;
      pending_q      <= 2'b01;
      seen_v_q       <= 1'b0;
      vinfo_q        <= 2'b01;
      field_id_q     <= 1'b0;
      lpf_q          <= '0;
      valid_q        <= 1'b0;
      mode_changed_q <= 1'b0;
    end else begin
      line_cnt_q     <= line_cnt_d;
      stab_q         <= stab_d;
      pending_q      <= pending_d;
      seen_v_q       <= seen_v_d;
      vinfo_q        <= vinfo_d;
      field_id_q     <= field_id_d;
      lpf_q          <= lpf_d;
      valid_q        <= valid_d;
      mode_changed_q <= mode_changed_d;
    end
  end

  assign vinfo_o           = vinfo_q;
  assign field_id_o        = field_id_q;
  assign lines_per_field_o = lpf_q;
  assign vmode_valid_o     = valid_q;
  assign mode_changed_o    = mode_changed_q;

endmodule

// File: tb/tb_n64_vmode_detect.sv
// Directed bench for n64_vmode_detect: expected output snapshots are queued
// as stimulus is driven and popped/compared after the DUT edge.
module tb_n64_vmode_detect;

  logic       VCLK = 1'b0;
  logic       RST;
  logic       nVDSYNC;
  logic [3:0] Sync_pre;
  logic [3:0] Sync_cur;
  logic [1:0] vinfo_o;
  logic       field_id_o;
  logic [9:0] lines_per_field_o;
  logic       vmode_valid_o;
  logic       mode_changed_o;

  always #5 VCLK = ~VCLK;

  n64_vmode_detect #(
    .LINECNT_W      (10),
    .PAL_LINE_THRESH(288),
    .STABLE_FIELDS  (4),
    .TIMEOUT_LINES  (640)
  ) dut (
    .VCLK             (VCLK),
    .RST              (RST),
    .nVDSYNC          (nVDSYNC),
    .Sync_pre         (Sync_pre),
    .Sync_cur         (Sync_cur),
    .vinfo_o          (vinfo_o),
    .field_id_o       (field_id_o),
    .lines_per_field_o(lines_per_field_o),
    .vmode_valid_o    (vmode_valid_o),
    .mode_changed_o   (mode_changed_o)
  );

  typedef struct {
    string      tag;
    logic [1:0] vinfo;
    logic       fid;
    logic [9:0] lpf;
    logic       valid;
    logic       mc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned pulse_cnt = 0;

  always @(negedge VCLK) if (mode_changed_o === 1'b1) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 2ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] pre, input logic [3:0] cur, input logic nv);
    Sync_pre = pre;
    Sync_cur = cur;
    nVDSYNC  = nv;
    @(posedge VCLK);
    #1;
    Sync_pre = 4'hF;
    Sync_cur = 4'hF;
  endtask

  task automatic push(input string tag, input logic [1:0] v, input logic f,
                      input logic [9:0] l, input logic val, input logic mc);
    exp_t e;
    e.tag = tag; e.vinfo = v; e.fid = f; e.lpf = l; e.valid = val; e.mc = mc;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, "_vinfo"}, 32'(vinfo_o),           32'(e.vinfo));
    chk({e.tag, "_fid"},   32'(field_id_o),        32'(e.fid));
    chk({e.tag, "_lpf"},   32'(lines_per_field_o), 32'(e.lpf));
    chk({e.tag, "_valid"}, 32'(vmode_valid_o),     32'(e.valid));
    chk({e.tag, "_mc"},    32'(mode_changed_o),    32'(e.mc));
  endtask

  task automatic hs(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(4'hF, 4'hD, 1'b0);
  endtask

  // VSYNC falling edge, optionally with a coincident HSYNC falling edge.
  task automatic vs_chk(input logic h, input string tag, input logic [1:0] v,
                        input logic f, input logic [9:0] l, input logic val,
                        input logic mc);
    push(tag, v, f, l, val, mc);
    cyc(4'hF, h ? 4'h5 : 4'h7, 1'b0);
    compare_front();
  endtask

  task automatic snap(input string tag, input logic [1:0] v, input logic f,
                      input logic [9:0] l, input logic val, input logic mc);
    push(tag, v, f, l, val, mc);
    compare_front();
  endtask

  initial begin
    RST = 1'b1; nVDSYNC = 1'b0; Sync_pre = 4'hF; Sync_cur = 4'hF;

    // Reset values
    push("reset", 2'b01, 1'b0, 10'd0, 1'b0, 1'b0);
    cyc(4'hF, 4'hF, 1'b0);
    RST = 1'b0;
    compare_front();

    // NTSC 240p: 263-line fields, commit on the 5th VSYNC
    for (int i = 0; i < 5; i++) begin
      hs(263);
      vs_chk(1'b0, "ntsc240p", (i == 4) ? 2'b00 : 2'b01, 1'b0, 10'd263,
             i == 4, i == 4);
    end
    cyc(4'hF, 4'hF, 1'b0);
    chk("ntsc_mc_clear", 32'(mode_changed_o), 32'd0);
    chk("ntsc_pulses", 32'(pulse_cnt), 32'd1);

    // Single-field glitch followed by return to NTSC: no change
    hs(313);
    vs_chk(1'b0, "glitch_pal", 2'b00, 1'b0, 10'd313, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hs(263);
      vs_chk(1'b0, "glitch_back", 2'b00, 1'b0, 10'd263, 1'b1, 1'b0);
    end
    chk("glitch_pulses", 32'(pulse_cnt), 32'd1);

    // Sustained switch to 313-line fields commits 10 on the 4th field
    for (int i = 0; i < 4; i++) begin
      hs(313);
      vs_chk(1'b0, "pal240p", (i == 3) ? 2'b10 : 2'b00, 1'b0, 10'd313,
             1'b1, i == 3);
    end
    cyc(4'hF, 4'hF, 1'b0);
    chk("pal240p_pulses", 32'(pulse_cnt), 32'd2);

    // Reset mid-field discards the partial field
    hs(100);
    RST = 1'b1;
    push("reset_mid", 2'b01, 1'b0, 10'd0, 1'b0, 1'b0);
    cyc(4'hF, 4'hD, 1'b0);
    RST = 1'b0;
    compare_front();

    // PAL 480i: alternating 312/313 with alternating parity
    for (int i = 0; i < 5; i++) begin
      hs((i % 2 == 0) ? 312 : 313);
      vs_chk((i % 2 == 0), "pal480i", (i == 4) ? 2'b11 : 2'b01,
             (i % 2 == 0), (i % 2 == 0) ? 10'd312 : 10'd313, i == 4, i == 4);
    end
    cyc(4'hF, 4'hF, 1'b0);
    chk("pal480i_pulses", 32'(pulse_cnt), 32'd3);

    // Coincident VSYNC/HSYNC edges
    hs(50);
    vs_chk(1'b1, "coinc", 2'b11, 1'b1, 10'd50, 1'b1, 1'b0);
    hs(20);
    vs_chk(1'b0, "coinc_next", 2'b11, 1'b0, 10'd20, 1'b1, 1'b0);

    // Disabled cycles must not move any state
    hs(10);
    push("hold", 2'b11, 1'b0, 10'd20, 1'b1, 1'b0);
    cyc(4'hF, 4'hD, 1'b1);
    cyc(4'hF, 4'h7, 1'b1);
    cyc(4'hF, 4'h5, 1'b1);
    compare_front();
    vs_chk(1'b0, "hold_release", 2'b11, 1'b0, 10'd10, 1'b1, 1'b0);

    // Timeout at 640 lines, then counter saturation and revalidation
    hs(639);
    snap("pre_timeout", 2'b11, 1'b0, 10'd10, 1'b1, 1'b0);
    hs(1);
    snap("timeout", 2'b11, 1'b0, 10'd10, 1'b0, 1'b0);
    hs(400);
    vs_chk(1'b0, "reval_seen", 2'b11, 1'b0, 10'd1023, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      hs(313);
      vs_chk(1'b0, "reval", (i == 3) ? 2'b10 : 2'b11, 1'b0, 10'd313,
             i == 3, i == 3);
    end
    cyc(4'hF, 4'hF, 1'b0);
    chk("reval_pulses", 32'(pulse_cnt), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
